// File: rtl/logic_accum_pkg.sv
// logic_accum_pkg: operation encodings and FSM states shared by logic_accum
package logic_accum_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: combinational two-input bitwise operation selected by op
module logic_op_unit
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // NOR folds as OR; the single inversion happens at the result port
    always_comb y = (op == OP_AND) ? (a & b) : (op == OP_XOR) ? (a ^ b) : (a | b);

endmodule

// File: rtl/logic_accum.sv
// logic_accum: folds a stream of operands with a bitwise operation into one result
module logic_accum
    import logic_accum_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int MAX_OPS = 8,
    localparam int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CW-1:0]    count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state, state_nx;
    op_t              op_q;
    logic [CW-1:0]    cnt, tgt, clamp;
    logic [WIDTH-1:0] acc, acc_nx;
    logic             inv, hs, last;

    assign clamp = (count > CW'(MAX_OPS)) ? CW'(MAX_OPS) : count;
    assign hs    = in_valid & in_ready;
    assign last  = hs && (cnt + CW'(1) == tgt);

    logic_op_unit #(.WIDTH(WIDTH)) u_op (
        .op (op_q),
        .a  (acc),
        .b  (in_data),
        .y  (acc_nx)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = (state == IDLE && start)     ? ((clamp == '0) ? DONE : ACCUM) :
                    (state == ACCUM && last)     ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // job latch and accumulation; a zero-operand job reports the bare identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_OR;
            tgt  <= '0;
            cnt  <= '0;
            acc  <= '0;
            inv  <= 1'b0;
        end else if (state == IDLE && start) begin
            op_q <= op_t'(op);
            tgt  <= clamp;
            cnt  <= '0;
            acc  <= (op_t'(op) == OP_AND) ? '1 : '0;
            inv  <= (op_t'(op) == OP_NOR) && (clamp != '0);
        end else if (hs) begin
            acc  <= acc_nx;
            cnt  <= cnt + CW'(1);
        end
    end

    assign out_data = out_valid ? (inv ? ~acc : acc) : '0;

endmodule

// File: tb/tb_logic_accum.sv
// tb_logic_accum: randomized scoreboard bench for logic_accum
module tb_logic_accum;

    localparam int W  = 8;
    localparam int M  = 8;
    localparam int CW = $clog2(M + 1);

    logic          clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [1:0]    op = 0;
    logic [CW-1:0] count = 0;
    logic [W-1:0]  in_data = 0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  out_data;

    int           checks = 0, fails = 0;
    logic [W-1:0] expq[$];
    bit           hold = 0;
    logic         pv = 0;
    logic [W-1:0] pd = 0;

    logic_accum #(.WIDTH(W), .MAX_OPS(M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: fold operands from the operation's identity; NOR inverts a non-empty OR
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] d[$]);
        logic [W-1:0] r;
        r = (o == 2'b01) ? '1 : '0;
        foreach (d[i]) begin
            case (o)
                2'b01:   r = r & d[i];
                2'b10:   r = r ^ d[i];
                default: r = r | d[i];
            endcase
        end
        return (o == 2'b11 && d.size() > 0) ? ~r : r;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // monitor: stability while held, and scoreboard pop on each result handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && pv) chk("out_stable", out_data, pd);
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) chk("unexpected_out", 1, 0);
            else chk("out_data", out_data, expq.pop_front());
        end
        pv = rst_n && out_valid && !out_ready;
        pd = out_data;
    end

    task automatic job(input logic [1:0] o, input int cnt, input logic [W-1:0] d[$],
                       input int mingap, input int maxgap, input bit noise, input int rst_after);
        int n, t;
        logic [W-1:0] used[$];
        n = (cnt > M) ? M : cnt;
        for (int i = 0; i < n; i++) used.push_back(d[i]);
        if (rst_after < 0) expq.push_back(model(o, used));
        start = 1; op = o; count = CW'(cnt);
        cyc(1);
        start = 0;
        if (noise) begin op = 2'($urandom); count = CW'($urandom); end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(mingap, maxgap)) begin
                in_valid = 0;
                if (noise) start = 1'($urandom_range(0, 1));
                cyc(1);
            end
            if (rst_after == i) begin
                #2 rst_n = 0;
                #1;
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_out_data", out_data, 0);
                start = 0; in_valid = 0;
                @(posedge clk);
                #1 rst_n = 1;
                return;
            end
            in_valid = 1; in_data = d[i];
            t = 0;
            while (!in_ready && t < 50) begin cyc(1); t++; end
            if (t == 50) chk("in_ready_timeout", 0, 1);
            cyc(1);
        end
        in_valid = noise; in_data = 8'($urandom);
        start = 0;
        chk("out_valid_latency", out_valid, 1);
        chk("in_ready_after_last", in_ready, 0);
        if (noise) begin start = 1; op = 2'($urandom); count = CW'($urandom_range(1, M)); end
        t = 0;
        while (busy && t < 100) begin cyc(1); t++; end
        if (t == 100) chk("done_timeout", 0, 1);
        start = 0; in_valid = 0;
        cyc(1);
        chk("no_spurious_start", busy, 0);
    endtask

    initial begin
        logic [W-1:0] q[$];
        int t;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        cyc(2);
        rst_n = 1;
        in_valid = 1; in_data = 8'hFF;
        cyc(2);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
        in_valid = 0;

        q.delete(); q.push_back(8'h01); q.push_back(8'h10); q.push_back(8'h80);
        job(2'b00, 3, q, 0, 0, 0, -1);

        q.delete(); q.push_back(8'hF0); q.push_back(8'h3C);
        hold = 1;
        fork
            job(2'b01, 2, q, 2, 2, 0, -1);
            begin
                t = 0;
                while (!out_valid && t < 100) begin cyc(1); t++; end
                if (t == 100) chk("and_valid_timeout", 0, 1);
                cyc(3);
                chk("and_held_valid", out_valid, 1);
                hold = 0;
            end
        join

        q.delete();
        job(2'b11, 0, q, 0, 0, 0, -1);
        job(2'b01, 0, q, 0, 0, 0, -1);

        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        job(2'b10, 12, q, 0, 2, 0, -1);

        job(2'b00, 4, q, 0, 1, 0, 2);
        q.delete(); q.push_back(8'h5A);
        job(2'b00, 1, q, 0, 0, 0, -1);

        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        job(2'b10, 5, q, 1, 3, 1, -1);

        for (int j = 0; j < 40; j++) begin
            q.delete();
            for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
            job(2'($urandom), $urandom_range(0, 10), q, 0, 3, 1'($urandom_range(0, 1)), -1);
        end

        cyc(5);
        chk("scoreboard_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/logic_accum.md
LOGIC_ACCUM -- requirements
Module: logic_accum

Interface
REQ-001 Parameter WIDTH, default 32, bit width of operands and result.
REQ-002 Parameter MAX_OPS, default 8, maximum operands per job; CW = $clog2(MAX_OPS+1).
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  job request; sampled only in IDLE.
REQ-006 Op  input  2  operation latched at Start: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-007 Count  input  CW  operand count latched at Start.
REQ-008 In_valid  input  1  In_data valid.
REQ-009 In_ready  output  1  block accepts an operand this cycle.
REQ-010 In_data  input  WIDTH  operand.
REQ-011 Out_valid  output  1  result valid.
REQ-012 Out_ready  input  1  consumer accepts result.
REQ-013 Out_data  output  WIDTH  result.
REQ-014 Busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-016 IDLE with Start=1 SHALL latch Op and Count, load accumulator with identity (all-zeros for OR/XOR/NOR, all-ones for AND), go to ACCUM next cycle; latched Count=0 goes directly to DONE.
REQ-017 Count > MAX_OPS SHALL be clamped to MAX_OPS at latch time.
REQ-018 In_ready SHALL be 1 only in ACCUM; a handshake is In_valid & In_ready in the same cycle.
REQ-019 Each handshake SHALL update acc <= acc OP In_data (NOR accumulates as OR) and increment the operand counter.
REQ-020 Handshake on the final operand SHALL move to DONE; Out_valid SHALL assert the following cycle (one-cycle latency from last operand).
REQ-021 Out_data SHALL equal acc, bitwise-inverted for NOR, and SHALL be stable while Out_valid=1.
REQ-022 DONE SHALL hold Out_valid=1 until Out_ready=1; that cycle returns to IDLE, Out_valid=0 next cycle.
REQ-023 Start outside IDLE SHALL be ignored; Op/Count changes after latch SHALL have no effect.
REQ-024 Start asserted in the cycle DONE hands off SHALL be ignored; a new job needs Start in IDLE.
REQ-025 In_valid in IDLE or DONE SHALL be ignored with In_ready=0.
REQ-026 Arithmetic is bitwise only; no carries, no width growth.

Reset
REQ-027 Rst=0 SHALL immediately force IDLE, In_ready=0, Out_valid=0, Busy=0, Out_data=0, counter=0, acc=0, regardless of state.
REQ-028 Reset mid-job SHALL discard partial result; first post-reset job behaves as if none preceded it.

Structure
REQ-029 Package logic_accum_pkg SHALL hold Op encodings (OP_OR, OP_AND, OP_XOR, OP_NOR) and the state enumeration.
REQ-030 One sub-module logic_op_unit SHALL implement the combinational WIDTH-bit two-input operation selected by Op.
REQ-031 All state SHALL be registered on Clk with asynchronous reset on Rst low.

Verification
REQ-032 WIDTH=8: Op=OR, Count=3, operands 0x01,0x10,0x80 back-to-back -> Out_valid one cycle after third, Out_data=0x91.
REQ-033 Op=AND, Count=2, 0xF0 then 0x3C with 2 idle cycles between, Out_ready low 3 cycles -> Out_data=0x30 held stable until Out_ready.
REQ-034 Op=NOR, Count=0 -> DONE next cycle, Out_data=0x00; Op=AND, Count=0 -> Out_data=0xFF.
REQ-035 Op=XOR, Count=12 with MAX_OPS=8 -> exactly 8 operands accepted, In_ready=0 after eighth; Out_data = XOR of those 8.
REQ-036 Rst low after 2 of 4 operands -> all outputs 0 within same cycle; new OR job Count=1 operand 0x5A -> Out_data=0x5A.
REQ-037 Start pulsed during ACCUM and DONE, In_valid in IDLE -> no state change, result of running job unaffected.
